// File: rtl/mbist_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mbist_pkg
// Purpose : Shared types and constant March C- element table for the MBIST
//           march controller and its address generator.
// Contents: state_t (FSM states), elem_t (march element index),
//           march_elem_t (per-element direction / op count / r-w pattern),
//           march_table() lookup, march_up() direction helper.
// Revision: 1.0 - initial release
// ============================================================================
package mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [2:0] elem_t;

  localparam elem_t C_LAST_ELEM = 3'd5;

  // up     : 1 = ascending address order
  // nops   : operations per address (1 or 2)
  // rd/wr  : element contains a read / a write (read always comes first)
  // *_pat  : data background bit for read-expect / write
  typedef struct packed {
    logic       up;
    logic [1:0] nops;
    logic       rd;
    logic       wr;
    logic       rd_pat;
    logic       wr_pat;
  } march_elem_t;

  // March C-: up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0)
  function automatic march_elem_t march_table(input elem_t e);
    march_elem_t m;
    case (e)
      3'd0:    m = '{up: 1'b1, nops: 2'd1, rd: 1'b0, wr: 1'b1, rd_pat: 1'b0, wr_pat: 1'b0};
      3'd1:    m = '{up: 1'b1, nops: 2'd2, rd: 1'b1, wr: 1'b1, rd_pat: 1'b0, wr_pat: 1'b1};
      3'd2:    m = '{up: 1'b1, nops: 2'd2, rd: 1'b1, wr: 1'b1, rd_pat: 1'b1, wr_pat: 1'b0};
      3'd3:    m = '{up: 1'b0, nops: 2'd2, rd: 1'b1, wr: 1'b1, rd_pat: 1'b0, wr_pat: 1'b1};
      3'd4:    m = '{up: 1'b0, nops: 2'd2, rd: 1'b1, wr: 1'b1, rd_pat: 1'b1, wr_pat: 1'b0};
      3'd5:    m = '{up: 1'b1, nops: 2'd1, rd: 1'b1, wr: 1'b0, rd_pat: 1'b0, wr_pat: 1'b0};
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic march_up(input elem_t e);
    march_elem_t m;
    m = march_table(e);
    return m.up;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mbist_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : mbist_addr_gen
// Purpose : Up/down address counter with synchronous load, count enable and
//           a flag marking the final address in the current direction.
// Ports   : clk, rst_n       - clock, async active-low reset
//           load, load_val   - load a new start address (has priority)
//           en, up           - step the counter, direction select
//           addr, last       - current address, last-address-of-sweep flag
// Revision: 1.0 - initial release
// ============================================================================
module mbist_addr_gen #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_val,
  input  logic                  en,
  input  logic                  up,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] c_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (load) begin
      r_addr <= load_val;
    end else if (en) begin
      r_addr <= up ? (r_addr + c_one) : (r_addr - c_one);
    end
  end

  assign addr = r_addr;
  assign last = up ? (r_addr == '1) : (r_addr == '0);

endmodule
`default_nettype wire

// File: rtl/mbist_march_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mbist_march_ctrl
// Purpose : March C- memory BIST controller. Sequences 10N memory operations,
//           compares read data one cycle after each read strobe and records
//           the address of the first mismatch.
// Ports   : clk, rst_n            - clock, async active-low reset
//           start                 - launch pulse (honoured in IDLE/DONE only)
//           ram_rdata             - memory read data, one cycle after bist_re
//           NbarT                 - 1 while BIST owns the memory
//           bist_addr/wdata/we/re - memory command outputs
//           done, fail, fail_addr - completion, sticky fail, first bad address
// Revision: 1.0 - initial release
// ============================================================================
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  NbarT,
  output logic [ADDR_WIDTH-1:0] bist_addr,
  output logic [DATA_WIDTH-1:0] bist_wdata,
  output logic                  bist_we,
  output logic                  bist_re,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr
);

  state_t                r_state, w_state_nxt;
  elem_t                 r_elem;
  logic                  r_phase;        // 0 = first op at this address
  march_elem_t           w_cur;
  logic                  w_start, w_run;
  logic                  w_op_rd, w_op_wr;
  logic                  w_addr_done, w_elem_done, w_test_done;
  logic [ADDR_WIDTH-1:0] w_addr, w_load_val;
  logic                  w_addr_last, w_load, w_en;

  logic                  r_rd_vld;
  logic [DATA_WIDTH-1:0] r_exp;
  logic [ADDR_WIDTH-1:0] r_exp_addr;
  logic                  r_fail;
  logic [ADDR_WIDTH-1:0] r_fail_addr;

  assign w_cur   = march_table(r_elem);
  assign w_start = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_run   = (r_state == ST_RUN);

  // Two-op elements read on phase 0 and write on phase 1.
  assign w_op_rd     = w_run && w_cur.rd && !r_phase;
  assign w_op_wr     = w_run && w_cur.wr && (r_phase || !w_cur.rd);
  assign w_addr_done = w_run && ((w_cur.nops == 2'd1) || r_phase);
  assign w_elem_done = w_addr_done && w_addr_last;
  assign w_test_done = w_elem_done && (r_elem == C_LAST_ELEM);

  // Reload the sweep start on the last op of an element so the next element
  // begins on the very next cycle.
  assign w_load     = w_start || (w_elem_done && !w_test_done);
  assign w_load_val = (w_start || march_up(r_elem + 3'd1)) ? '0 : '1;
  assign w_en       = w_addr_done && !w_addr_last;

  mbist_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (w_en),
    .up       (w_cur.up),
    .addr     (w_addr),
    .last     (w_addr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    NbarT       = 1'b0;
    bist_addr   = '0;
    bist_wdata  = '0;
    bist_we     = 1'b0;
    bist_re     = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        NbarT      = 1'b1;
        bist_addr  = w_addr;
        bist_we    = w_op_wr;
        bist_re    = w_op_rd;
        bist_wdata = w_op_wr ? {DATA_WIDTH{w_cur.wr_pat}} : '0;
        if (w_test_done) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        NbarT       = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (w_start) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_elem  <= '0;
      r_phase <= 1'b0;
    end else if (w_start) begin
      r_elem  <= '0;
      r_phase <= 1'b0;
    end else if (w_run) begin
      if (w_addr_done) begin
        r_phase <= 1'b0;
        if (w_elem_done && !w_test_done) r_elem <= r_elem + 3'd1;
      end else begin
        r_phase <= 1'b1;
      end
    end
  end

  // Expected data and address travel one cycle behind the read strobe to
  // line up with the synchronous memory's read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld   <= 1'b0;
      r_exp      <= '0;
      r_exp_addr <= '0;
    end else begin
      r_rd_vld   <= w_op_rd;
      r_exp      <= {DATA_WIDTH{w_cur.rd_pat}};
      r_exp_addr <= w_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
    end else if (w_start) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
    end else if (r_rd_vld && (ram_rdata != r_exp) && !r_fail) begin
      r_fail      <= 1'b1;
      r_fail_addr <= r_exp_addr;
    end
  end

  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;

endmodule
`default_nettype wire

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, memory address width; depth N = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, memory word width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: start  input  1  pulse that launches a test, sampled only in IDLE and DONE.
REQ-005 SHALL have port: ram_rdata  input  DATA_WIDTH  memory read data, valid one cycle after bist_re.
REQ-006 SHALL have port: NbarT  output  1  mux select, 1 = BIST owns the memory.
REQ-007 SHALL have port: bist_addr  output  ADDR_WIDTH  BIST address.
REQ-008 SHALL have port: bist_wdata  output  DATA_WIDTH  BIST write data.
REQ-009 SHALL have port: bist_we  output  1  write strobe.
REQ-010 SHALL have port: bist_re  output  1  read strobe.
REQ-011 SHALL have port: done  output  1  test complete, held until the next start.
REQ-012 SHALL have port: fail  output  1  sticky mismatch flag.
REQ-013 SHALL have port: fail_addr  output  ADDR_WIDTH  address of the first mismatch.

Function
REQ-014 SHALL execute March C-: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
REQ-015 SHALL drive data background 0 as all-zeros and 1 as all-ones, with the expected read value equal to the same pattern.
REQ-016 SHALL issue exactly one operation per RUN cycle: bist_we and bist_re are mutually exclusive and never both high.
REQ-017 SHALL, for (r,w) elements, read then write the same address on consecutive cycles before advancing the address.
REQ-018 SHALL count up elements from 0 to N-1 and down elements from N-1 to 0; the address reloads at each element boundary with no idle cycle.
REQ-019 SHALL implement FSM states IDLE, RUN, FLUSH and DONE, with transitions IDLE/DONE -start-> RUN; RUN -last op of E5-> FLUSH; FLUSH -> DONE.
REQ-020 SHALL, with start sampled high at edge k, present the first operation (addr 0, we=1, wdata 0) in cycle k+1 and the last of 10N operations in cycle k+10N.
REQ-021 SHALL use FLUSH, one cycle, only to compare the final read; no strobes are asserted in FLUSH.
REQ-022 SHALL raise done in cycle k+10N+2.
REQ-023 SHALL compare ram_rdata against a one-cycle-delayed expected value and address whenever the delayed read-valid is set.
REQ-024 SHALL set fail and load fail_addr on the first mismatch; later mismatches leave fail_addr unchanged, and the test runs to completion.
REQ-025 SHALL hold NbarT at 1 in RUN and FLUSH and at 0 in IDLE and DONE.
REQ-026 SHALL ignore start in RUN and FLUSH.
REQ-027 SHALL, on start in DONE, clear done, fail and fail_addr and restart identically to a start from IDLE.
REQ-028 SHALL drive bist_addr, bist_wdata and all strobes to 0 in IDLE, FLUSH and DONE.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-test, immediately force the state to IDLE and force NbarT, bist_we, bist_re, done and fail to 0.
REQ-030 SHALL, on rst_n low, also force bist_addr, bist_wdata, fail_addr and all internal counters and pipeline registers to 0.
REQ-031 SHALL, after rst_n deasserts, take no action until start.

Structure
REQ-032 SHALL place the FSM state enum, the element index type, and the constant march table (direction, op count, read/write pattern per element) in shared package mbist_pkg.
REQ-033 SHALL instantiate sub-module mbist_addr_gen, an up/down address counter with load, enable and last-address flag.

Verification (ADDR_WIDTH=6, DATA_WIDTH=8, synchronous RAM model, 1-cycle read)
REQ-034 SHALL verify the fault-free case: start at edge k -> 640 ops, done=1 at cycle k+642, fail=0, NbarT=1 for cycles k+1..k+641.
REQ-035 SHALL verify stuck-at-0 on bit 3 at address 0x15 -> first mismatch in E2 reading 0xF7, so fail=1 and fail_addr=0x15.
REQ-036 SHALL verify two faults, at 0x05 and 0x30 (stuck-at-1 bit 0) -> fail_addr=0x05 retained and the test still completes.
REQ-037 SHALL verify address order: E3 first op has bist_addr=0x3F with bist_re=1; E4 ends at 0x00; E5 starts at 0x00.
REQ-038 SHALL verify reset at cycle k+300 -> all outputs 0 asynchronously; a new start -> full 640-op run with done at +642.
REQ-039 SHALL verify start pulsed at k+100 is ignored; start in DONE clears fail and reruns.
